// File: rtl/i2c_rx_fifo.sv
// Receive buffer behind the I2C slave: synchronizes the byte strobe into clk_50M,
// optionally filters by address, and queues {addr, rec_d} in a first-word-fall-through FIFO.
module i2c_rx_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter bit          FILTER_EN = 1'b1,
  parameter logic [6:0]  DEV_ADDR  = 7'h50
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic                     d_val_async,
  input  logic [7:0]               rec_d,
  input  logic [6:0]               addr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic [6:0]               rd_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     filt_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          s1, s2, s3;
  logic          edge_det;
  logic          addr_ok;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [14:0]   mem [DEPTH];

  // Chain resets to 1 so a strobe already high at reset release never produces an edge.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= d_val_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    edge_det  = s2 & ~s3;
    addr_ok   = !FILTER_EN || (addr == DEV_ADDR);
    filt_drop = edge_det & ~addr_ok;
    push_req  = edge_det & addr_ok;
    rd_valid  = (count != '0);
    full      = (count == CW'(DEPTH));
    pop       = rd_valid & rd_ready;
    push      = push_req & (~full | pop);
    drop      = push_req & full & ~pop;
    rd_data   = mem[rd_ptr][7:0];
    rd_addr   = mem[rd_ptr][14:8];
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr: the new entry lands in the slot being freed.
  always_ff @(posedge clk_50M) begin
    if (push) mem[wr_ptr] <= {addr, rec_d};
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_rx_fifo.sv
// Self-checking bench for i2c_rx_fifo: queue-based reference model, directed scenarios, then randomized traffic.
module tb_i2c_rx_fifo;

  localparam int unsigned DEPTH = 8;
  localparam logic [6:0]  DEV   = 7'h50;

  logic       clk_50M = 1'b0;
  logic       rst = 1'b1;
  logic       d_val_async = 1'b0;
  logic [7:0] rec_d = '0;
  logic [6:0] addr = '0;
  logic       rd_ready = 1'b0;
  logic       ovf_clr = 1'b0;

  logic       rd_valid, overflow, filt_drop;
  logic [7:0] rd_data;
  logic [6:0] rd_addr;
  logic [3:0] count;

  logic       nf_rd_valid, nf_overflow, nf_filt_drop;
  logic [7:0] nf_rd_data;
  logic [6:0] nf_rd_addr;
  logic [3:0] nf_count;

  always #10 clk_50M = ~clk_50M;

  i2c_rx_fifo #(.DEPTH(DEPTH), .FILTER_EN(1'b1), .DEV_ADDR(DEV)) u_dut (
    .clk_50M(clk_50M), .rst(rst), .d_val_async(d_val_async), .rec_d(rec_d), .addr(addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr), .filt_drop(filt_drop)
  );

  // Unfiltered instance that drains continuously: each strobe shows up for exactly one cycle.
  i2c_rx_fifo #(.DEPTH(DEPTH), .FILTER_EN(1'b0), .DEV_ADDR(DEV)) u_nof (
    .clk_50M(clk_50M), .rst(rst), .d_val_async(d_val_async), .rec_d(rec_d), .addr(addr),
    .rd_valid(nf_rd_valid), .rd_ready(1'b1), .rd_data(nf_rd_data), .rd_addr(nf_rd_addr),
    .count(nf_count), .overflow(nf_overflow), .ovf_clr(1'b0), .filt_drop(nf_filt_drop)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [14:0] q[$];
  bit          m_ovf = 1'b0;
  int          since_rise = -1;
  bit          rand_mode = 1'b0;
  bit          pop_at_arr = 1'b0;
  int          ready_lvl = 5;
  bit          nf_exp = 1'b0;
  logic [14:0] nf_ent = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("rd_valid", int'(rd_valid), int'(q.size() != 0));
    check("count", int'(count), q.size());
    check("overflow", int'(overflow), int'(m_ovf));
    check("filt_drop", int'(filt_drop), int'(since_rise == 2 && addr != DEV));
    if (q.size() != 0) begin
      check("rd_data", int'(rd_data), int'(q[0][7:0]));
      check("rd_addr", int'(rd_addr), int'(q[0][14:8]));
    end
    check("nf_rd_valid", int'(nf_rd_valid), int'(nf_exp));
    check("nf_count", int'(nf_count), int'(nf_exp));
    check("nf_overflow", int'(nf_overflow), 0);
    check("nf_filt_drop", int'(nf_filt_drop), 0);
    if (nf_exp) begin
      check("nf_rd_data", int'(nf_rd_data), int'(nf_ent[7:0]));
      check("nf_rd_addr", int'(nf_rd_addr), int'(nf_ent[14:8]));
    end
  endtask

  // One clock: byte arrival happens on the third edge after the strobe rises.
  task automatic cycle();
    bit          arrive, pop, drop, rr, oc;
    logic [14:0] ent;
    if (rand_mode) begin
      rd_ready = ($urandom_range(0, 9) < ready_lvl);
      ovf_clr  = ($urandom_range(0, 15) == 0);
    end
    if (pop_at_arr) rd_ready = (since_rise == 2);
    arrive = (since_rise == 2);
    ent    = {addr, rec_d};
    rr     = rd_ready;
    oc     = ovf_clr;
    @(posedge clk_50M);
    pop = (q.size() != 0) && rr;
    if (pop) void'(q.pop_front());
    drop = 1'b0;
    if (arrive && addr == DEV) begin
      if (q.size() < DEPTH) q.push_back(ent);
      else drop = 1'b1;
    end
    if (drop)    m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
    nf_exp = arrive;
    nf_ent = ent;
    if (since_rise >= 0) since_rise++;
    #1;
    check_outputs();
    if (since_rise >= 3) since_rise = -1;
  endtask

  task automatic strobe(input logic [6:0] a, input logic [7:0] d, input int hi, input int lo);
    addr = a;
    rec_d = d;
    d_val_async = 1'b1;
    since_rise = 0;
    repeat (hi) cycle();
    d_val_async = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    since_rise = -1;
    nf_exp = 1'b0;
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_filt_drop", int'(filt_drop), 0);
    check("rst_nf_count", int'(nf_count), 0);
    @(negedge clk_50M);
    @(negedge clk_50M);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_50M);
    check("init_rd_valid", int'(rd_valid), 0);
    check("init_count", int'(count), 0);
    check("init_overflow", int'(overflow), 0);
    check("init_filt_drop", int'(filt_drop), 0);
    rst = 1'b0;
    repeat (2) cycle();

    // single byte
    strobe(DEV, 8'hA5, 4, 4);
    rd_ready = 1'b1; cycle();
    rd_ready = 1'b0; cycle();

    // filtered address
    strobe(7'h51, 8'h3C, 3, 3);

    // fill, overflow, drain, clear
    for (int i = 0; i < 8; i++) strobe(DEV, 8'(i), 3, 3);
    strobe(DEV, 8'h08, 3, 3);
    rd_ready = 1'b1; repeat (10) cycle();
    rd_ready = 1'b0;
    ovf_clr = 1'b1; cycle();
    ovf_clr = 1'b0; cycle();

    // full with a pop on the arrival edge
    for (int i = 0; i < 8; i++) strobe(DEV, 8'(i), 3, 3);
    pop_at_arr = 1'b1;
    strobe(DEV, 8'h08, 3, 3);
    pop_at_arr = 1'b0;
    rd_ready = 1'b1; repeat (10) cycle();

    // wrap-around with continuous draining
    for (int i = 0; i < 20; i++) strobe(DEV, 8'(8'h40 + i), 3, 3);

    // reset with a strobe in flight
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe(DEV, 8'(8'h70 + i), 3, 3);
    addr = DEV; rec_d = 8'h77; d_val_async = 1'b1; since_rise = 0;
    cycle();
    do_reset();
    repeat (5) cycle();
    d_val_async = 1'b0;
    repeat (4) cycle();
    strobe(DEV, 8'h88, 3, 3);
    rd_ready = 1'b1; repeat (3) cycle();

    // randomized traffic with varying consumer throughput
    rand_mode = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      ready_lvl = (blk % 3 == 0) ? 0 : (blk % 3 == 1) ? 2 : 8;
      for (int k = 0; k < 50; k++) begin
        strobe(($urandom_range(0, 3) == 0) ? 7'($urandom) : DEV, 8'($urandom),
               $urandom_range(3, 5), $urandom_range(3, 8));
      end
    end
    rand_mode = 1'b0;
    ovf_clr = 1'b0;
    rd_ready = 1'b1;
    repeat (12) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
